tx_byte_serializer: RTL and testbench



---
 rtl/tx_byte_serializer_pkg.sv | 43 ++++
 rtl/tx_byte_serializer_if.sv | 14 +
 rtl/tx_word_slot.sv | 48 ++++
 rtl/tx_byte_serializer.sv | 107 ++++++++++
 tb/tb_tx_byte_serializer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_byte_serializer_pkg.sv
// Shared types and lane helpers for the 32-bit to 8-bit AXI-stream serializer.
package tx_byte_serializer_pkg;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = LANES * BYTE_W;

  typedef logic [LANES-1:0] mask_t;
  typedef logic [1:0]       lane_t;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    mask_t             mask;
    logic              last;
  } slot_t;

  function automatic lane_t lowest_lane(input mask_t m);
    lane_t l;
    l = 2'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) begin
        l = lane_t'(i);
      end else begin
        l = l;
      end
    end
    return l;
  endfunction

  function automatic logic [2:0] popcount(input mask_t m);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      c = c + {2'b00, m[i]};
    end
    return c;
  endfunction

  function automatic mask_t clear_lowest(input mask_t m);
    return m & (m - 4'b0001);
  endfunction

endpackage

// File: rtl/tx_byte_serializer_if.sv
// AXI-stream bundle used for both the 32-bit intake side and the 8-bit output side.
interface tx_byte_serializer_if #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/tx_word_slot.sv
// One word of serializer storage: data word, remaining-lane mask and last flag.
module tx_word_slot
  import tx_byte_serializer_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  load,
  input  slot_t load_val,
  input  logic  clr_lowest,
  input  logic  set_last,
  input  logic  clear,
  output slot_t q
);

  slot_t slot_nxt_s;

  // Next slot contents; a slot whose mask drains is zeroed so it reads as empty.
  always_comb begin
    slot_nxt_s = q;
    if (load) begin
      slot_nxt_s      = load_val;
      slot_nxt_s.last = load_val.last | set_last;
    end else if (clear) begin
      slot_nxt_s = '0;
    end else begin
      if (clr_lowest) begin
        slot_nxt_s.mask = clear_lowest(q.mask);
      end else begin
        slot_nxt_s.mask = q.mask;
      end
      if (slot_nxt_s.mask == 4'b0000) begin
        slot_nxt_s = '0;
      end else begin
        slot_nxt_s.last = q.last | set_last;
      end
    end
  end

  // Slot register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else begin
      q <= slot_nxt_s;
    end
  end

endmodule

// File: rtl/tx_byte_serializer.sv
// Splits tkeep-qualified 32-bit words into a byte stream, dropping empty lanes and
// folding a trailing keep=0/tlast beat onto the last real byte of the packet.
module tx_byte_serializer
  import tx_byte_serializer_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic                  clk,
  input  logic                  rstn,
  tx_byte_serializer_if.slave   i_axis,
  tx_byte_serializer_if.master  o_axis,
  output logic [CNT_W-1:0]      byte_count,
  output logic                  empty_pkt
);

  slot_t      cur_s, nxt_s, in_slot_s, cur_load_val_s;
  logic       cur_valid_s, nxt_valid_s, o_valid_s;
  logic [2:0] cur_pop_s;
  lane_t      lane_s;
  logic       fire_s, cur_final_s, accept_s, word_in_s, eop_in_s;
  logic       post_cur_valid_s, post_cur_last_s, merge_s, orphan_s;
  logic       cur_load_s, nxt_load_s, nxt_clear_s;

  assign cur_valid_s = |cur_s.mask;
  assign nxt_valid_s = |nxt_s.mask;

  // Handshakes and slot control; the shift is resolved before the intake lands.
  always_comb begin
    cur_pop_s   = popcount(cur_s.mask);
    lane_s      = lowest_lane(cur_s.mask);
    // The final byte of a non-last word waits for whatever follows it.
    o_valid_s   = cur_valid_s & ((cur_pop_s > 3'd1) | cur_s.last | nxt_valid_s);
    fire_s      = o_valid_s & o_axis.tready;
    cur_final_s = fire_s & (cur_pop_s == 3'd1);
    accept_s    = i_axis.tvalid & ~nxt_valid_s;
    word_in_s   = accept_s & (i_axis.tkeep != 4'b0000);
    eop_in_s    = accept_s & (i_axis.tkeep == 4'b0000) & i_axis.tlast;

    post_cur_valid_s = cur_final_s ? nxt_valid_s : cur_valid_s;
    post_cur_last_s  = cur_final_s ? nxt_s.last  : cur_s.last;
    // NXT is always empty when a beat is accepted, so CUR is the only merge target.
    merge_s  = eop_in_s & post_cur_valid_s & ~post_cur_last_s;
    orphan_s = eop_in_s & ~merge_s;

    in_slot_s.word = i_axis.tdata;
    in_slot_s.mask = i_axis.tkeep;
    in_slot_s.last = i_axis.tlast;

    if (cur_final_s & nxt_valid_s) begin
      cur_load_s     = 1'b1;
      cur_load_val_s = nxt_s;
    end else if (word_in_s & ~post_cur_valid_s) begin
      cur_load_s     = 1'b1;
      cur_load_val_s = in_slot_s;
    end else begin
      cur_load_s     = 1'b0;
      cur_load_val_s = in_slot_s;
    end
    nxt_load_s  = word_in_s & post_cur_valid_s;
    nxt_clear_s = cur_final_s;
  end

  tx_word_slot u_cur (
    .clk        (clk),
    .rstn       (rstn),
    .load       (cur_load_s),
    .load_val   (cur_load_val_s),
    .clr_lowest (fire_s),
    .set_last   (merge_s),
    .clear      (1'b0),
    .q          (cur_s)
  );

  tx_word_slot u_nxt (
    .clk        (clk),
    .rstn       (rstn),
    .load       (nxt_load_s),
    .load_val   (in_slot_s),
    .clr_lowest (1'b0),
    .set_last   (1'b0),
    .clear      (nxt_clear_s),
    .q          (nxt_s)
  );

  assign i_axis.tready = ~nxt_valid_s;
  assign o_axis.tvalid = o_valid_s;
  assign o_axis.tdata  = cur_s.word[{lane_s, 3'b000} +: BYTE_W];
  assign o_axis.tlast  = cur_s.last & (cur_pop_s == 3'd1);
  assign o_axis.tkeep  = '1;

  // Statistics counter and orphaned-terminator pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_count <= '0;
      empty_pkt  <= 1'b0;
    end else begin
      if (fire_s) begin
        byte_count <= byte_count + CNT_W'(1);
      end else begin
        byte_count <= byte_count;
      end
      empty_pkt <= orphan_s;
    end
  end

endmodule

// File: tb/tb_tx_byte_serializer.sv
// Self-checking bench for tx_byte_serializer: vector table, directed corner cases, random vs model.
module tb_tx_byte_serializer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] byte_count;
  logic        empty_pkt;

  always #5 clk = ~clk;

  tx_byte_serializer_if #(.DATA_W(32), .KEEP_W(4)) i_if ();
  tx_byte_serializer_if #(.DATA_W(8),  .KEEP_W(1)) o_if ();

  tx_byte_serializer #(.CNT_W(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_axis     (i_if),
    .o_axis     (o_if),
    .byte_count (byte_count),
    .empty_pkt  (empty_pkt)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    int          n;
    logic [31:0] exp;
    int          ep;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          rdy_mode = 0;
  int          cyc = 0;
  int          since_rst = 0;
  int          ep_cnt = 0;
  int          model_ep = 0;
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_out = 9'd0;
  logic        saw_full = 1'b0;
  logic [8:0]  cap_q[$];
  logic [8:0]  exp_q[$];
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the falling edge.
  task automatic step(input logic vld, input logic [31:0] d, input logic [3:0] k,
                      input logic l, output logic acc);
    logic rdy;
    @(negedge clk);
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = (cyc % 2 == 0);
      default: rdy = ($urandom_range(0, 3) != 0);
    endcase
    cyc++;
    i_if.tvalid = vld;
    i_if.tdata  = d;
    i_if.tkeep  = k;
    i_if.tlast  = l;
    o_if.tready = rdy;
    #1;
    if (prev_stall) chk("stall_hold", {22'd0, o_if.tvalid, o_if.tlast, o_if.tdata}, {22'd0, 1'b1, prev_out});
    chk("byte_count", byte_count, since_rst);
    if (vld && !i_if.tready) saw_full = 1'b1;
    acc = vld & i_if.tready;
    if (empty_pkt) ep_cnt++;
    if (o_if.tvalid && rdy) begin
      cap_q.push_back({o_if.tlast, o_if.tdata});
      since_rst++;
    end
    prev_stall = o_if.tvalid & ~rdy;
    prev_out   = {o_if.tlast, o_if.tdata};
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 4'd0, 1'b0, a);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic a;
    a = 1'b0;
    for (int t = 0; t < 50 && !a; t++) step(1'b1, d, k, l, a);
    if (!a) begin
      errors++;
      $display("FAIL send_timeout: got no i_tready expected accept within 50 cycles");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    i_if.tvalid = 1'b0;
    o_if.tready = 1'b0;
    #1;
    chk("rst_tvalid", {31'd0, o_if.tvalid}, 32'd0);
    chk("rst_count", byte_count, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    since_rst = 0;
    ep_cnt = 0;
    prev_stall = 1'b0;
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic push_exp(input logic [7:0] b, input logic l);
    exp_q.push_back({l, b});
  endtask

  task automatic cmp_cap(input string name);
    chk({name, "_len"}, cap_q.size(), exp_q.size());
    while (exp_q.size() > 0 && cap_q.size() > 0) chk(name, {23'd0, cap_q.pop_front()}, {23'd0, exp_q.pop_front()});
    exp_q.delete();
    cap_q.delete();
  endtask

  // Reference: each accepted beat appends its kept bytes in lane order; a bare
  // terminator marks the newest undelivered byte as last or else is orphaned.
  task automatic model_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic [8:0] t;
    if (k != 4'd0) begin
      for (int ln = 0; ln < 4; ln++) if (k[ln]) exp_q.push_back({1'b0, d[8*ln +: 8]});
      if (l) begin
        t = exp_q[exp_q.size() - 1];
        t[8] = 1'b1;
        exp_q[exp_q.size() - 1] = t;
      end
    end else if (l) begin
      if (exp_q.size() > 0 && !exp_q[exp_q.size() - 1][8]) begin
        t = exp_q[exp_q.size() - 1];
        t[8] = 1'b1;
        exp_q[exp_q.size() - 1] = t;
      end else begin
        model_ep++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    logic       a;
    logic       vld, l;
    logic [31:0] d;
    logic [3:0] k;
    logic [8:0] got;

    vecs[0] = '{32'hDDCCBBAA, 4'b1010, 2, 32'h0000DDBB, 0};
    vecs[1] = '{32'hDDCCBBAA, 4'b1111, 4, 32'hDDCCBBAA, 0};
    vecs[2] = '{32'hDDCCBBAA, 4'b0001, 1, 32'h000000AA, 0};
    vecs[3] = '{32'hDDCCBBAA, 4'b1000, 1, 32'h000000DD, 0};
    vecs[4] = '{32'h11223344, 4'b0110, 2, 32'h00002233, 0};
    vecs[5] = '{32'h11223344, 4'b1001, 2, 32'h00001144, 0};
    vecs[6] = '{32'h11223344, 4'b0000, 0, 32'h00000000, 1};

    i_if.tvalid = 1'b0;
    i_if.tdata  = 32'd0;
    i_if.tkeep  = 4'd0;
    i_if.tlast  = 1'b0;
    o_if.tready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("reset_tvalid", {31'd0, o_if.tvalid}, 32'd0);
    chk("reset_tlast", {31'd0, o_if.tlast}, 32'd0);
    chk("reset_tdata", {24'd0, o_if.tdata}, 32'd0);
    chk("reset_empty", {31'd0, empty_pkt}, 32'd0);
    chk("reset_count", byte_count, 32'd0);
    chk("reset_iready", {31'd0, i_if.tready}, 32'd1);
    chk("reset_okeep", {31'd0, o_if.tkeep}, 32'd1);

    // Single-word packets from the table.
    for (int v = 0; v < 7; v++) begin
      ep_cnt = 0;
      send_beat(vecs[v].data, vecs[v].keep, 1'b1);
      idle(8);
      for (int j = 0; j < vecs[v].n; j++) push_exp(vecs[v].exp[8*j +: 8], j == vecs[v].n - 1);
      cmp_cap("vec_bytes");
      chk("vec_empty_pkt", ep_cnt, vecs[v].ep);
    end

    // Length 6.
    do_reset();
    send_beat(32'h02030405, 4'b1111, 1'b0);
    send_beat(32'hEEFF0001, 4'b0011, 1'b1);
    idle(8);
    for (int j = 5; j >= 0; j--) push_exp(8'(j), j == 0);
    cmp_cap("len6");
    chk("len6_count", byte_count, 32'd6);

    // Length 8 closed by a bare terminator; byte 00 is held until it arrives.
    do_reset();
    send_beat(32'h04050607, 4'b1111, 1'b0);
    send_beat(32'h00010203, 4'b1111, 1'b0);
    idle(12);
    chk("len8_held_cnt", cap_q.size(), 32'd7);
    chk("len8_held_valid", {31'd0, o_if.tvalid}, 32'd0);
    send_beat(32'h0, 4'b0000, 1'b1);
    idle(6);
    for (int j = 7; j >= 0; j--) push_exp(8'(j), j == 0);
    cmp_cap("len8");
    chk("len8_empty_pkt", ep_cnt, 32'd0);

    // Isolated terminator.
    do_reset();
    send_beat(32'h0, 4'b0000, 1'b1);
    idle(4);
    chk("iso_bytes", cap_q.size(), 32'd0);
    chk("iso_empty_pkt", ep_cnt, 32'd1);
    chk("iso_count", byte_count, 32'd0);

    // 12 bytes with o_tready toggling.
    do_reset();
    rdy_mode = 1;
    saw_full = 1'b0;
    send_beat(32'h08090A0B, 4'b1111, 1'b0);
    send_beat(32'h04050607, 4'b1111, 1'b0);
    send_beat(32'h00010203, 4'b1111, 1'b1);
    idle(30);
    for (int j = 11; j >= 0; j--) push_exp(8'(j), j == 0);
    cmp_cap("stall12");
    chk("stall12_full", {31'd0, saw_full}, 32'd1);
    rdy_mode = 0;

    // Reset after 3 of 8 bytes, then a clean length-4 packet.
    do_reset();
    send_beat(32'h04050607, 4'b1111, 1'b0);
    send_beat(32'h00010203, 4'b1111, 1'b1);
    for (int t = 0; t < 20 && cap_q.size() < 3; t++) idle(1);
    chk("midrst_progress", cap_q.size(), 32'd3);
    do_reset();
    send_beat(32'h00010203, 4'b1111, 1'b1);
    idle(8);
    for (int j = 3; j >= 0; j--) push_exp(8'(j), j == 0);
    cmp_cap("post_rst4");

    // Random traffic against the reference model.
    do_reset();
    rdy_mode = 2;
    model_ep = 0;
    for (int c = 0; c < 3000; c++) begin
      vld = ($urandom_range(0, 9) < 7);
      d   = $urandom;
      k   = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      l   = ($urandom_range(0, 3) == 0);
      step(vld, d, k, l, a);
      while (cap_q.size() > 0) begin
        got = cap_q.pop_front();
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL rand_extra: got %0h expected no byte", got);
        end else begin
          chk("rand_byte", {23'd0, got}, {23'd0, exp_q.pop_front()});
        end
      end
      if (a) model_beat(d, k, l);
    end
    rdy_mode = 0;
    send_beat(32'h0, 4'b0000, 1'b1);
    model_beat(32'h0, 4'b0000, 1'b1);
    idle(20);
    while (cap_q.size() > 0 && exp_q.size() > 0) chk("rand_drain", {23'd0, cap_q.pop_front()}, {23'd0, exp_q.pop_front()});
    chk("rand_left_exp", exp_q.size(), 32'd0);
    chk("rand_left_cap", cap_q.size(), 32'd0);
    chk("rand_empty_pkt", ep_cnt, model_ep);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
